// File: rtl/cmp_eqge_serial.sv
// Digit-serial unsigned comparator (eq = a==b, ge = a>=b), MSB-first, DIGIT bits/cycle.
// Define CMP_SERIAL_EARLY_EXIT_EN to stop at the first differing digit; else constant time.
module cmp_eqge_serial #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic             eq_o,
   output logic             ge_o
);

   localparam int N  = (WIDTH + DIGIT - 1) / DIGIT;
   localparam int PW = N * DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

   state_t          state_q;
   logic [PW-1:0]   a_q;
   logic [PW-1:0]   b_q;
   logic [CW-1:0]   cnt_q;
   logic [PW-1:0]   sa;
   logic [PW-1:0]   sb;
   logic [DIGIT-1:0] da;
   logic [DIGIT-1:0] db;
   logic            dif;
   logic            gt;
   logic            last;

`ifndef CMP_SERIAL_EARLY_EXIT_EN
   logic            dec_q;
   logic            gt_q;
`endif

   // Current digit is selected by shifting it down to the LSBs.
   always_comb begin
      sa   = a_q >> (cnt_q * DIGIT);
      sb   = b_q >> (cnt_q * DIGIT);
      da   = sa[DIGIT-1:0];
      db   = sb[DIGIT-1:0];
      dif  = (da != db);
      gt   = (da > db);
      last = (cnt_q == '0);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         in_ready_o  <= 1'b1;
         out_valid_o <= 1'b0;
         eq_o        <= 1'b0;
         ge_o        <= 1'b0;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
`ifndef CMP_SERIAL_EARLY_EXIT_EN
         dec_q       <= 1'b0;
         gt_q        <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid_i && in_ready_o) begin
                  a_q        <= PW'(a_i);
                  b_q        <= PW'(b_i);
                  cnt_q      <= CW'(N - 1);
                  in_ready_o <= 1'b0;
                  state_q    <= SCAN;
`ifndef CMP_SERIAL_EARLY_EXIT_EN
                  dec_q      <= 1'b0;
                  gt_q       <= 1'b0;
`endif
               end
            end
            SCAN: begin
`ifdef CMP_SERIAL_EARLY_EXIT_EN
               if (dif) begin
                  eq_o        <= 1'b0;
                  ge_o        <= gt;
                  out_valid_o <= 1'b1;
                  state_q     <= DONE;
               end else if (last) begin
                  eq_o        <= 1'b1;
                  ge_o        <= 1'b1;
                  out_valid_o <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
`else
               // First differing digit decides; later digits are ignored.
               if (!dec_q && dif) begin
                  dec_q <= 1'b1;
                  gt_q  <= gt;
               end
               if (last) begin
                  out_valid_o <= 1'b1;
                  state_q     <= DONE;
                  if (dec_q) begin
                     eq_o <= 1'b0;
                     ge_o <= gt_q;
                  end else if (dif) begin
                     eq_o <= 1'b0;
                     ge_o <= gt;
                  end else begin
                     eq_o <= 1'b1;
                     ge_o <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
`endif
            end
            DONE: begin
               if (out_ready_i) begin
                  out_valid_o <= 1'b0;
                  in_ready_o  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_o <= 1'b0;
               in_ready_o  <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_eqge_serial.sv
// Directed bench for cmp_eqge_serial: 16/4 and 10/4 instances.
// Expected latencies follow CMP_SERIAL_EARLY_EXIT_EN.
module tb_cmp_eqge_serial;

`ifdef CMP_SERIAL_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   logic        clk;
   logic        rst_n;

   logic        v16, ir16, ov16, or16, eq16, ge16;
   logic [15:0] a16, b16;
   logic        v10, ir10, ov10, or10, eq10, ge10;
   logic [9:0]  a10, b10;

   logic        sel;
   logic        ir, ov, eq, ge;

   int n_assert;
   int n_fail;

   cmp_eqge_serial #(.WIDTH(16), .DIGIT(4)) u16 (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (v16),
      .in_ready_o  (ir16),
      .a_i         (a16),
      .b_i         (b16),
      .out_valid_o (ov16),
      .out_ready_i (or16),
      .eq_o        (eq16),
      .ge_o        (ge16)
   );

   cmp_eqge_serial #(.WIDTH(10), .DIGIT(4)) u10 (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .in_valid_i  (v10),
      .in_ready_o  (ir10),
      .a_i         (a10),
      .b_i         (b10),
      .out_valid_o (ov10),
      .out_ready_i (or10),
      .eq_o        (eq10),
      .ge_o        (ge10)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      ir = sel ? ir10 : ir16;
      ov = sel ? ov10 : ov16;
      eq = sel ? eq10 : eq16;
      ge = sel ? ge10 : ge16;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] a,
                        input logic [15:0] b);
      if (sel) begin
         v10 = v;
         a10 = a[9:0];
         b10 = b[9:0];
      end else begin
         v16 = v;
         a16 = a;
         b16 = b;
      end
   endtask

   task automatic set_ordy(input logic r);
      if (sel) or10 = r;
      else     or16 = r;
   endtask

   task automatic run_op(input string tag, input logic [15:0] a,
                         input logic [15:0] b, input logic eq_e,
                         input logic ge_e, input int k_e, input bit hold);
      int k;
      @(negedge clk);
      chk({tag, ".in_ready_idle"}, 32'(ir), 32'd1);
      drive(1'b1, a, b);
      @(posedge clk);
      #1;
      // scramble inputs: operands must not be re-sampled
      drive(1'b0, ~a, 16'h5a5a);
      chk({tag, ".in_ready_busy"}, 32'(ir), 32'd0);
      k = 0;
      while (ov == 1'b0 && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk({tag, ".out_valid"}, 32'(ov), 32'd1);
      chk({tag, ".latency"}, 32'(k), 32'(k_e));
      chk({tag, ".eq"}, 32'(eq), 32'(eq_e));
      chk({tag, ".ge"}, 32'(ge), 32'(ge_e));
      if (hold) begin
         for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_valid"}, 32'(ov), 32'd1);
            chk({tag, ".hold_eq"}, 32'(eq), 32'(eq_e));
            chk({tag, ".hold_ge"}, 32'(ge), 32'(ge_e));
            chk({tag, ".hold_ready"}, 32'(ir), 32'd0);
         end
      end
      set_ordy(1'b1);
      @(posedge clk);
      #1;
      set_ordy(1'b0);
      chk({tag, ".post_valid"}, 32'(ov), 32'd0);
      chk({tag, ".post_ready"}, 32'(ir), 32'd1);
      chk({tag, ".keep_eq"}, 32'(eq), 32'(eq_e));
      chk({tag, ".keep_ge"}, 32'(ge), 32'(ge_e));
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      sel      = 1'b0;
      rst_n    = 1'b0;
      v16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0;
      v10 = 1'b0; or10 = 1'b0; a10 = '0; b10 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.in_ready", 32'(ir16), 32'd1);
      chk("rst.out_valid", 32'(ov16), 32'd0);
      chk("rst.eq", 32'(eq16), 32'd0);
      chk("rst.ge", 32'(ge16), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("eq1234", 16'h1234, 16'h1234, 1'b1, 1'b1, 4, 1'b0);
      run_op("gt8000", 16'h8000, 16'h7fff, 1'b0, 1'b1, EE ? 1 : 4, 1'b0);
      run_op("lt12f0", 16'h12f0, 16'h12f1, 1'b0, 1'b0, 4, 1'b1);
      run_op("eq0000", 16'h0000, 16'h0000, 1'b1, 1'b1, 4, 1'b0);
      run_op("lt0100", 16'h0100, 16'h0200, 1'b0, 1'b0, EE ? 2 : 4, 1'b0);

      // abort in the second SCAN cycle
      @(negedge clk);
      drive(1'b1, 16'h0001, 16'h0002);
      @(posedge clk);
      #1;
      drive(1'b0, 16'h0000, 16'h0000);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort.out_valid", 32'(ov16), 32'd0);
      chk("abort.in_ready", 32'(ir16), 32'd1);
      chk("abort.eq", 32'(eq16), 32'd0);
      chk("abort.ge", 32'(ge16), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("abort.no_result", 32'(ov16), 32'd0);

      run_op("gt5_3", 16'h0005, 16'h0003, 1'b0, 1'b1, 4, 1'b0);

      sel = 1'b1;
      run_op("w10_1ff", 16'h01ff, 16'h01fe, 1'b0, 1'b1, 3, 1'b0);
      run_op("w10_3ff", 16'h03ff, 16'h03ff, 1'b1, 1'b1, 3, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
